// File: rtl/instr_sequencer_pkg.sv
// instr_sequencer_pkg: shared types and constants for the instruction sequencer
package instr_sequencer_pkg;
  localparam int IW = 16;
  localparam logic [IW-1:0] HALT_DEFAULT = 16'h0000;
  typedef enum logic [2:0] {IDLE, FETCH, ISSUE, WAIT, HALTED} state_t;
endpackage

// File: rtl/instr_store.sv
// instr_store: DEPTH x W synchronous single-write/single-read RAM, no reset
module instr_store import instr_sequencer_pkg::*; #(
  parameter int DEPTH = 16,
  parameter int AW = 4,
  parameter int W = IW
) (
  input  logic          clock,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);
  logic [W-1:0] mem [DEPTH];
  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end
endmodule

// File: rtl/instr_sequencer.sv
// instr_sequencer: feeds stored instructions to the core one at a time, with halt and done-watchdog
module instr_sequencer import instr_sequencer_pkg::*; #(
  parameter int DEPTH = 16,
  parameter int AW = 4,
  parameter logic [IW-1:0] HALT_WORD = HALT_DEFAULT,
  parameter bit WRAP = 1'b0,
  parameter int TIMEOUT = 64
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          load_en,
  input  logic [AW-1:0] load_addr,
  input  logic [IW-1:0] load_data,
  input  logic          start,
  input  logic          done,
  output logic [IW-1:0] iin,
  output logic          run,
  output logic [AW-1:0] pc,
  output logic          busy,
  output logic          halted,
  output logic          timeout_err
);
  localparam int WW = $clog2(TIMEOUT);
  state_t state, state_n;
  logic [AW-1:0] pc_n;
  logic [WW-1:0] wd, wd_n;
  logic [IW-1:0] rdata, iin_q;
  logic terr_n;
  instr_store #(.DEPTH(DEPTH), .AW(AW), .W(IW)) u_store (
    .clock(clock), .we(load_en && !busy), .waddr(load_addr), .wdata(load_data),
    .raddr(pc), .rdata(rdata)
  );
  assign busy = state == FETCH || state == ISSUE || state == WAIT;
  assign halted = state == HALTED;
  assign run = state == ISSUE && rdata != HALT_WORD;
  // the store output is only valid in ISSUE, so iin is held in a register otherwise
  assign iin = run ? rdata : iin_q;
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      pc <= '0;
      wd <= '0;
      timeout_err <= 1'b0;
      iin_q <= '0;
    end else begin
      state <= state_n;
      pc <= pc_n;
      wd <= wd_n;
      timeout_err <= terr_n;
      if (run) iin_q <= rdata;
    end
  end
  // the watchdog trips on the cycle it would reach TIMEOUT-1, so WAIT lasts TIMEOUT-1 cycles
  always_comb begin
    state_n = state;
    pc_n = pc;
    wd_n = wd;
    terr_n = timeout_err;
    case (state)
      IDLE, HALTED: if (start) begin
        state_n = FETCH;
        pc_n = '0;
        terr_n = 1'b0;
      end
      FETCH: state_n = ISSUE;
      ISSUE: begin
        state_n = run ? WAIT : HALTED;
        wd_n = '0;
      end
      WAIT: if (done) begin
        state_n = (pc == AW'(DEPTH - 1) && !WRAP) ? HALTED : FETCH;
        pc_n = (pc == AW'(DEPTH - 1) && !WRAP) ? pc : pc + 1'b1;
      end else if (wd == WW'(TIMEOUT - 2)) begin
        state_n = HALTED;
        terr_n = 1'b1;
      end else wd_n = wd + 1'b1;
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: tb/tb_instr_sequencer.sv
// tb_instr_sequencer: table, directed and random checks of instr_sequencer against a transaction model
module tb_instr_sequencer;
  import instr_sequencer_pkg::*;
  logic clock = 0, reset = 1, load_en = 0, start = 0, done_a = 0, done_b = 0;
  logic [1:0] load_addr = '0;
  logic [15:0] load_data = '0;
  logic [15:0] iin_a, iin_b;
  logic [1:0] pc_a, pc_b;
  logic run_a, run_b, busy_a, busy_b, halted_a, halted_b, terr_a, terr_b;

  instr_sequencer #(.DEPTH(4), .AW(2), .WRAP(1'b0), .TIMEOUT(8)) dut_a (
    .clock(clock), .reset(reset), .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
    .start(start), .done(done_a), .iin(iin_a), .run(run_a), .pc(pc_a), .busy(busy_a),
    .halted(halted_a), .timeout_err(terr_a));
  instr_sequencer #(.DEPTH(4), .AW(2), .WRAP(1'b1), .TIMEOUT(8)) dut_b (
    .clock(clock), .reset(reset), .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
    .start(start), .done(done_b), .iin(iin_b), .run(run_b), .pc(pc_b), .busy(busy_b),
    .halted(halted_b), .timeout_err(terr_b));

  always #5 clock = ~clock;
  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {int cyc; int pc; int w;} ev_t;
  typedef struct {logic [15:0] w0, w1, w2, w3; int d; int runs; int hoff; int hpc; int herr;} vec_t;
  ev_t exp_q[$], obs_q[$];
  int dly_q[$];
  logic [15:0] prog [4];
  int checks = 0, failures = 0;
  int e_hoff, e_hpc, e_herr, o_hoff, o_hpc, o_herr, o_busy;

  task automatic chk(input string nm, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  task automatic load4(input logic [15:0] w0, w1, w2, w3);
    prog[0] = w0; prog[1] = w1; prog[2] = w2; prog[3] = w3;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      load_en = 1; load_addr = 2'(i); load_data = prog[i];
    end
    @(negedge clock);
    load_en = 0;
  endtask

  task automatic settle();
    repeat (12) @(negedge clock);
  endtask

  // Transaction model: walk the program by the issue/advance/halt rules, timing in cycles after start
  task automatic model(input bit wrap);
    int t = 2, p = 0, idx = 0, j;
    exp_q.delete();
    while (1) begin
      if (prog[p] == 16'h0000) begin e_hoff = t + 1; e_hpc = p; e_herr = 0; break; end
      exp_q.push_back('{t, p, int'(prog[p])});
      j = (idx < dly_q.size() && dly_q[idx] >= 0) ? dly_q[idx] + 1 : 1000;
      idx++;
      if (j >= 8) begin e_hoff = t + 8; e_hpc = p; e_herr = 1; break; end
      if (p == 3 && !wrap) begin e_hoff = t + j + 1; e_hpc = 3; e_herr = 0; break; end
      p = (p + 1) % 4;
      t += j + 2;
    end
  endtask

  // Start the selected DUT and act as the core: done comes dly+1 cycles after each run (-1 = never)
  task automatic exec(input bit sel);
    int s, c, idx = 0, done_at = -1;
    bit fin = 0;
    obs_q.delete();
    @(negedge clock);
    s = cyc; start = 1;
    for (int k = 0; k < 400 && !fin; k++) begin
      @(negedge clock);
      start = 0; c = cyc;
      if (sel ? run_b : run_a) begin
        obs_q.push_back('{c - s, int'(sel ? pc_b : pc_a), int'(sel ? iin_b : iin_a)});
        done_at = (idx < dly_q.size() && dly_q[idx] >= 0) ? c + dly_q[idx] + 1 : -1;
        idx++;
      end
      if (sel ? halted_b : halted_a) begin
        fin = 1; done_at = -1;
        o_hoff = c - s; o_hpc = int'(sel ? pc_b : pc_a);
        o_herr = int'(sel ? terr_b : terr_a); o_busy = int'(sel ? busy_b : busy_a);
      end
      done_a = !sel && c == done_at;
      done_b = sel && c == done_at;
    end
    done_a = 0; done_b = 0;
    if (!fin) begin
      checks++; failures++;
      $display("FAIL exec_bound got=no_halt exp=halt");
      o_hoff = -1; o_hpc = -1; o_herr = -1; o_busy = -1;
    end
  endtask

  task automatic compare(input string nm);
    chk({nm, "_runs"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      chk($sformatf("%s_cyc%0d", nm, i), obs_q[i].cyc, exp_q[i].cyc);
      chk($sformatf("%s_pc%0d", nm, i), obs_q[i].pc, exp_q[i].pc);
      chk($sformatf("%s_iin%0d", nm, i), obs_q[i].w, exp_q[i].w);
    end
    chk({nm, "_halt_cyc"}, o_hoff, e_hoff);
    chk({nm, "_halt_pc"}, o_hpc, e_hpc);
    chk({nm, "_terr"}, o_herr, e_herr);
    chk({nm, "_busy"}, o_busy, 0);
  endtask

  vec_t tbl [6];
  logic [15:0] wv [4];
  logic [15:0] w [4];
  bit sel;
  int n;

  initial begin
    tbl[0] = '{16'hA01C, 16'hA40A, 16'h2080, 16'h0000, 1, 3, 15, 3, 0};
    tbl[1] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444, 0, 4, 13, 3, 0};
    tbl[2] = '{16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0, -1, 1, 10, 0, 1};
    tbl[3] = '{16'h0000, 16'h5678, 16'h9ABC, 16'hDEF0, 0, 0, 3, 0, 0};
    tbl[4] = '{16'hC001, 16'hC002, 16'hC003, 16'hC004, 6, 4, 37, 3, 0};
    tbl[5] = '{16'hBEEF, 16'hC002, 16'hC003, 16'hC004, 7, 1, 10, 0, 1};
    repeat (3) @(negedge clock);
    chk("rst_iin", iin_a, 0);
    chk("rst_flags", {run_a, busy_a, halted_a, terr_a}, 0);
    chk("rst_pc", pc_a, 0);
    reset = 0;
    @(negedge clock);

    for (int v = 0; v < 6; v++) begin
      load4(tbl[v].w0, tbl[v].w1, tbl[v].w2, tbl[v].w3);
      wv = '{tbl[v].w0, tbl[v].w1, tbl[v].w2, tbl[v].w3};
      dly_q = '{tbl[v].d, tbl[v].d, tbl[v].d, tbl[v].d};
      exec(0);
      chk($sformatf("tbl%0d_runs", v), obs_q.size(), tbl[v].runs);
      chk($sformatf("tbl%0d_halt_cyc", v), o_hoff, tbl[v].hoff);
      chk($sformatf("tbl%0d_halt_pc", v), o_hpc, tbl[v].hpc);
      chk($sformatf("tbl%0d_terr", v), o_herr, tbl[v].herr);
      for (int i = 0; i < obs_q.size() && i < tbl[v].runs; i++) begin
        chk($sformatf("tbl%0d_iin%0d", v, i), obs_q[i].w, int'(wv[i]));
        chk($sformatf("tbl%0d_pc%0d", v, i), obs_q[i].pc, i);
      end
      settle();
    end

    load4(16'h0101, 16'h0202, 16'h0303, 16'h0404);
    dly_q = '{0, 0, 0, 0, 0, 0, -1};
    model(1);
    exec(1);
    compare("wrap");
    settle();

    load4(16'hAAAA, 16'hBBBB, 16'h0000, 16'h0000);
    @(negedge clock);
    start = 1;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clock);
      chk($sformatf("ign_run%0d", i), run_a, int'(i == 2 || i == 8));
      if (i == 2) begin chk("ign_iin0", iin_a, 16'hAAAA); chk("ign_pc0", pc_a, 0); end
      if (i == 8) begin chk("ign_iin1", iin_a, 16'hBBBB); chk("ign_pc1", pc_a, 1); end
      if (i == 12) begin chk("ign_halted", halted_a, 1); chk("ign_halt_pc", pc_a, 2); end
      done_a = i == 1 || i == 2 || i == 6 || i == 7 || i == 9;
      start = i == 1 || i == 2 || i == 4;
      load_en = start; load_addr = 2'd0; load_data = 16'h5555;
    end
    done_a = 0; start = 0; load_en = 0;
    settle();
    dly_q = '{0, 0};
    model(0);
    exec(0);
    compare("ign_store");
    settle();

    load4(16'h1111, 16'h2222, 16'h3333, 16'h0000);
    @(negedge clock);
    start = 1;
    @(negedge clock); start = 0;
    @(negedge clock);
    @(negedge clock); done_a = 1;
    @(negedge clock); done_a = 0;
    @(negedge clock); chk("mid_run", run_a, 1);
    @(negedge clock);
    @(negedge clock);
    chk("mid_pc", pc_a, 1);
    chk("mid_iin", iin_a, 16'h2222);
    chk("mid_busy", busy_a, 1);
    #2 reset = 1;
    #1;
    chk("mid_rst_iin", iin_a, 0);
    chk("mid_rst_flags", {run_a, busy_a, halted_a, terr_a}, 0);
    chk("mid_rst_pc", pc_a, 0);
    @(negedge clock); reset = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      chk($sformatf("post_rst_idle%0d", i), {run_a, busy_a, halted_a}, 0);
    end
    dly_q = '{0, 0, 0};
    model(0);
    exec(0);
    compare("retain");
    settle();

    for (int r = 0; r < 25; r++) begin
      sel = 1'($urandom_range(0, 1));
      for (int i = 0; i < 4; i++) w[i] = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom_range(1, 16'hFFFF));
      dly_q.delete();
      n = $urandom_range(1, 8);
      for (int i = 0; i < n; i++) dly_q.push_back($urandom_range(0, 8));
      dly_q.push_back(-1);
      load4(w[0], w[1], w[2], w[3]);
      model(sel);
      exec(sel);
      compare($sformatf("rnd%0d", r));
      settle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/instr_sequencer.md
Name: instr_sequencer

Overview:
- Upstream feeder for the 16-bit processor core.
- Holds a small loadable instruction store and a program counter.
- Presents one instruction word at a time on the core's instruction input, pulses `run`, and waits for the core's `done` before advancing.
- Replaces hand-timed instruction stimulus with a self-sequencing program source, including halt detection and a done-watchdog.

Parameters:
- DEPTH, 16, number of 16-bit instruction words in the store (power of two, ≥2)
- AW, 4, address/PC width (log2 DEPTH)
- HALT_WORD, 16'h0000, instruction word that terminates the program; never issued to the core
- WRAP, 0, 1 = PC wraps DEPTH-1→0; 0 = running past DEPTH-1 halts
- TIMEOUT, 64, max cycles spent in WAIT before the watchdog trips (≥2)

Ports:
- clock, in, 1, system clock, all state updates on rising edge
- reset, in, 1, asynchronous active-high reset
- load_en, in, 1, write load_data into store at load_addr (honoured only in IDLE/HALTED)
- load_addr, in, AW, store write address
- load_data, in, 16, store write data
- start, in, 1, single-cycle pulse: begin execution at PC=0
- done, in, 1, core finished current instruction (sampled only in WAIT)
- iin, out, 16, instruction word driven to the core
- run, out, 1, one-cycle pulse: iin is a new instruction
- pc, out, AW, address of the instruction currently issued/awaited
- busy, out, 1, high in FETCH/ISSUE/WAIT
- halted, out, 1, high in HALTED
- timeout_err, out, 1, sticky: watchdog tripped; cleared by reset or next accepted start

Behaviour:
- Reset (async, immediate): state=IDLE, pc=0, iin=0, run=0, busy=0, halted=0, timeout_err=0, watchdog=0. Store contents are not reset.
- Reset mid-operation: aborts with no further run pulse; the outputs above apply.
- Store: synchronous write; synchronous read with 1-cycle latency. Read address = pc.
- FSM:
  - IDLE: start=1 → FETCH, pc=0, timeout_err cleared.
  - FETCH (1 cycle, read in flight) → ISSUE.
  - ISSUE:
    - If read word == HALT_WORD → HALTED; run stays 0.
    - Otherwise iin ← word, run=1 for exactly this cycle → WAIT, watchdog=0.
  - WAIT: watchdog increments each cycle.
    - done=1 → advance PC, then FETCH.
    - Advance rule: pc==DEPTH-1 and WRAP=0 → HALTED with pc held; else pc ← pc+1 (mod DEPTH).
    - Watchdog reaching TIMEOUT-1 with done=0 → HALTED, timeout_err=1.
    - done and timeout in the same cycle: done wins.
  - HALTED: start=1 → FETCH, pc=0, timeout_err cleared; otherwise hold.
- Issue cadence: minimum 3 cycles from one run pulse to the next (WAIT with done on the first cycle → FETCH → ISSUE).
- iin holds its last issued value until the next issue; never glitches in FETCH/WAIT/HALTED.
- Ignored inputs:
  - start while busy.
  - load_en while busy (store unchanged).
  - done outside WAIT.
- load_en and start in the same IDLE cycle: the write completes; FETCH then reads the updated word if load_addr==0.
- busy and halted are mutually exclusive; both 0 in IDLE.

Decomposition:
- Shared package:
  - state enum {IDLE, FETCH, ISSUE, WAIT, HALTED}
  - instruction word width (16)
  - default HALT_WORD constant
- Sub-module: instr_store — DEPTH×16 synchronous single-write/single-read RAM (no reset). Also reusable as data memory.
- FSM, PC and watchdog stay in instr_sequencer.

Test Plan:
- Basic run:
  - Stimulus: load [0]=16'hA01C, [1]=16'hA40A, [2]=16'h2080, [3]=HALT_WORD; start; core model asserts done 2 cycles after each run.
  - Response: three run pulses with iin = A01C, A40A, 2080 in order; pc = 0, 1, 2; then halted=1, busy=0, pc=3, no fourth run.
- Wrap:
  - Stimulus: WRAP=1, DEPTH=4, no halt word, done immediate; start.
  - Response: pc sequence 0,1,2,3,0,1,…; run pulses exactly 3 cycles apart.
- No-wrap end:
  - Stimulus: WRAP=0, DEPTH=4, no halt word, done immediate; start.
  - Response: 4 run pulses; halted=1 with pc=3.
- Watchdog:
  - Stimulus: TIMEOUT=8; core never asserts done.
  - Response: halted=1, timeout_err=1 exactly 8 cycles after the run pulse.
  - Then: start → timeout_err=0 and execution resumes at pc=0.
- Ignored inputs while busy: start, load_en to addr 0 and stray done (outside WAIT) → store and pc unaffected; no extra run.
- Reset mid-WAIT: assert reset between clock edges → all outputs zero immediately; after release, idle until start; store contents retained.
